// File: rtl/axi_read_master.sv
// AXI4 read master: accepts a burst command (start address, arlen), issues a
// single INCR read-address request, and streams the returned beats through
// a one-deep registered output stage. Flags a non-OKAY response and an rlast
// that disagrees with the beat count; both flags are sticky until the next
// command is accepted. Burst end is decided by the beat count alone.
module axi_read_master #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     resp_err,
    output logic                     last_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Bytes per beat expressed as the AXI size code.
    localparam logic [2:0] ARSIZE_C  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] ARBURST_C = 2'b01;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] araddr_r;
    logic [7:0]               arlen_r;
    logic                     arvalid_r;
    logic [7:0]               beat_cnt_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic                     out_last_r;
    logic                     out_valid_r;
    logic                     done_r;
    logic                     resp_err_r;
    logic                     last_err_r;

    logic                     cmd_ready_s;
    logic                     rready_s;
    logic                     cmd_hs_s;
    logic                     ar_hs_s;
    logic                     r_hs_s;
    logic                     out_hs_s;
    logic                     last_beat_s;

    // A beat may enter the output stage only when it is empty or draining.
    assign cmd_ready_s = (state_r == IDLE);
    assign rready_s    = (state_r == DATA) && (!out_valid_r || out_ready);
    assign cmd_hs_s    = cmd_valid && cmd_ready_s;
    assign ar_hs_s     = (state_r == ADDR) && arvalid_r && arready;
    assign r_hs_s      = rvalid && rready_s;
    assign out_hs_s    = out_valid_r && out_ready;
    assign last_beat_s = (beat_cnt_r == arlen_r);

    assign cmd_ready = cmd_ready_s;
    assign rready    = rready_s;
    assign araddr    = araddr_r;
    assign arlen     = arlen_r;
    assign arsize    = ARSIZE_C;
    assign arburst   = ARBURST_C;
    assign arvalid   = arvalid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign resp_err  = resp_err_r;
    assign last_err  = last_err_r;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: command -> address phase -> data phase -> idle on the counted last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_hs_s) state_nxt_s = ADDR;
                else          state_nxt_s = IDLE;
            end
            ADDR: begin
                if (ar_hs_s) state_nxt_s = DATA;
                else         state_nxt_s = ADDR;
            end
            DATA: begin
                if (r_hs_s && last_beat_s) state_nxt_s = IDLE;
                else                       state_nxt_s = DATA;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read-address channel: capture the command and hold it until the slave takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr_r  <= '0;
            arlen_r   <= 8'd0;
            arvalid_r <= 1'b0;
        end else if (cmd_hs_s) begin
            araddr_r  <= cmd_addr;
            arlen_r   <= cmd_len;
            arvalid_r <= 1'b1;
        end else if (ar_hs_s) begin
            arvalid_r <= 1'b0;
        end
    end

    // Beat counter: restarts when the address is accepted, advances per accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_r <= 8'd0;
        end else if (ar_hs_s) begin
            beat_cnt_r <= 8'd0;
        end else if (r_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end
    end

    // Output stage: a new beat reloads it, otherwise a consumer handshake empties it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (r_hs_s) begin
            out_data_r  <= rdata;
            out_last_r  <= last_beat_s;
            out_valid_r <= 1'b1;
        end else if (out_hs_s) begin
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end
    end

    // Single-cycle completion pulse on the counted final beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_r <= 1'b0;
        end else begin
            done_r <= r_hs_s && last_beat_s;
        end
    end

    // Sticky error flags, cleared when a new command is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resp_err_r <= 1'b0;
            last_err_r <= 1'b0;
        end else if (cmd_hs_s) begin
            resp_err_r <= 1'b0;
            last_err_r <= 1'b0;
        end else if (r_hs_s) begin
            if (rresp != 2'b00)        resp_err_r <= 1'b1;
            if (rlast != last_beat_s)  last_err_r <= 1'b1;
        end
    end

endmodule
